output_argmax: RTL and testbench

- Downstream classification stage for the output layer of the MNIST network.
- Consumes the 8-bit outputs of the NUM_CLASSES output-layer neurons, one per valid beat, in class order 0..NUM_CLASSES-1.
- Buffers every score and tracks the running signed maximum.
- When the last score arrives, presents the winning class index and its score with a ready flag, using the same start/ready style as the neuron.

---
 rtl/output_argmax_if.sv | 27 ++
 rtl/output_argmax.sv | 105 ++++++++++
 tb/tb_output_argmax.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/output_argmax_if.sv
// Score stream, readback and result bus between the output layer and the argmax stage.
// The master drives scores and readback addresses; the slave returns the classification.
interface output_argmax_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0]  out_class;
  logic [DATA_W-1:0] out_max;
  logic              busy;
  logic              ready;
  logic              err;

  modport master (
    output start, in_valid, in_data, rd_addr,
    input  rd_data, out_class, out_max, busy, ready, err
  );

  modport slave (
    input  start, in_valid, in_data, rd_addr,
    output rd_data, out_class, out_max, busy, ready, err
  );
endinterface

// File: rtl/output_argmax.sv
// Collects NUM_CLASSES signed scores in class order, buffers them and reports the
// index and value of the largest one (lowest index wins ties).
module output_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 8,
    parameter int IDX_W       = 4
) (
    input logic            clk,
    input logic            rst,
    output_argmax_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t            state_reg;
  logic [IDX_W-1:0]  count_reg;
  logic [IDX_W-1:0]  out_class_reg;
  logic [DATA_W-1:0] out_max_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              busy_reg;
  logic              ready_reg;
  logic              err_reg;
  logic [DATA_W-1:0] score_mem [NUM_CLASSES];
  logic              wr_en;
  logic              is_greater;

  // start takes precedence, so a coincident sample never reaches the buffer
  assign wr_en      = (state_reg == COLLECT) && bus.in_valid && !bus.start;
  assign is_greater = $signed(bus.in_data) > $signed(out_max_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_mem[i] <= '0;
      end
    end else if (wr_en) begin
      score_mem[count_reg] <= bus.in_data;
    end
  end

  // Readback sees the pre-write contents when the same entry is written this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (int'(bus.rd_addr) < NUM_CLASSES) begin
      rd_data_reg <= score_mem[bus.rd_addr];
    end else begin
      rd_data_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      out_class_reg <= '0;
      out_max_reg   <= '0;
      busy_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else if (bus.start) begin
      state_reg <= COLLECT;
      count_reg <= '0;
      busy_reg  <= 1'b1;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (bus.in_valid) begin
            if (count_reg == '0) begin
              out_max_reg   <= bus.in_data;
              out_class_reg <= '0;
            end else if (is_greater) begin
              out_max_reg   <= bus.in_data;
              out_class_reg <= count_reg;
            end
            if (count_reg == LAST_IDX) begin
              state_reg <= DONE;
              count_reg <= '0;
              busy_reg  <= 1'b0;
              ready_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        default: begin
          // Stray beats outside a collection are dropped but flagged
          if (bus.in_valid) begin
            err_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.out_class = out_class_reg;
  assign bus.out_max   = out_max_reg;
  assign bus.busy      = busy_reg;
  assign bus.ready     = ready_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: scenario tasks with hand-computed expectations.
module tb_output_argmax;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] vec [10];

  output_argmax_if #(.DATA_W(8), .IDX_W(4)) bus_if ();

  output_argmax #(.NUM_CLASSES(10), .DATA_W(8), .IDX_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
  endtask

  // Feeds vec[0..9]; inserts gap_len idle cycles after beat index gap_at
  task automatic feed(input int gap_at, input int gap_len);
    for (int i = 0; i < 10; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = vec[i];
      step();
      bus_if.in_valid = 1'b0;
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          step();
          checks++;
          if (bus_if.busy !== 1'b1 || bus_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL gap_busy cycle %0d got busy=%b ready=%b exp busy=1 ready=0", g, bus_if.busy, bus_if.ready);
          end
        end
      end
      if (i == 8) begin
        checks++;
        if (bus_if.ready !== 1'b0) begin
          errors++;
          $display("FAIL early_ready got %b exp 0", bus_if.ready);
        end
      end
    end
  endtask

  task automatic check_result(input string name, input logic [3:0] exp_class, input logic [7:0] exp_max);
    checks++;
    if (bus_if.ready !== 1'b1 || bus_if.busy !== 1'b0 ||
        bus_if.out_class !== exp_class || bus_if.out_max !== exp_max) begin
      errors++;
      $display("FAIL %s got ready=%b busy=%b class=%0d max=%h exp ready=1 busy=0 class=%0d max=%h",
               name, bus_if.ready, bus_if.busy, bus_if.out_class, bus_if.out_max, exp_class, exp_max);
    end
    $display("%s: class=%0d max=%h", name, bus_if.out_class, bus_if.out_max);
  endtask

  task automatic check_read(input string name, input logic [3:0] addr, input logic [7:0] exp);
    bus_if.rd_addr = addr;
    step();
    checks++;
    if (bus_if.rd_data !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d got %h exp %h", name, addr, bus_if.rd_data, exp);
    end
    $display("%s: rd_addr=%0d rd_data=%h", name, addr, bus_if.rd_data);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus_if.out_class !== 4'd0 || bus_if.out_max !== 8'd0 || bus_if.rd_data !== 8'd0 ||
        bus_if.busy !== 1'b0 || bus_if.ready !== 1'b0 || bus_if.err !== 1'b0) begin
      errors++;
      $display("FAIL %s got class=%0d max=%h rd=%h busy=%b ready=%b err=%b exp all 0",
               name, bus_if.out_class, bus_if.out_max, bus_if.rd_data, bus_if.busy, bus_if.ready, bus_if.err);
    end
    $display("%s: outputs after reset checked", name);
  endtask

  task automatic test_reset();
    bus_if.rd_addr = 4'd0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic test_back_to_back();
    pulse_start();
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL start_busy got busy=%b ready=%b exp busy=1 ready=0", bus_if.busy, bus_if.ready);
    end
    vec = '{8'd3, 8'hFB, 8'd17, 8'd0, 8'd9, 8'd17, 8'd2, 8'hFF, 8'd4, 8'd6};
    feed(-1, 0);
    check_result("back_to_back", 4'd2, 8'd17);
    check_read("buf5", 4'd5, 8'd17);
    check_read("buf1", 4'd1, 8'hFB);
  endtask

  task automatic test_negative_gap();
    pulse_start();
    vec = '{8'h80, 8'hF9, 8'h9C, 8'hF9, 8'hCE, 8'hF7, 8'h80, 8'hE2, 8'hF8, 8'hC4};
    feed(4, 3);
    check_result("negative_gap", 4'd1, 8'hF9);
  endtask

  task automatic test_last_index();
    pulse_start();
    vec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd127};
    feed(-1, 0);
    check_result("last_index", 4'd9, 8'd127);
    check_read("buf9", 4'd9, 8'd127);
    check_read("buf_oob", 4'd12, 8'd0);
  endtask

  task automatic test_err();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'd50;
    step();
    bus_if.in_valid = 1'b0;
    checks++;
    if (bus_if.err !== 1'b1 || bus_if.ready !== 1'b1 ||
        bus_if.out_class !== 4'd9 || bus_if.out_max !== 8'd127) begin
      errors++;
      $display("FAIL err_set got err=%b ready=%b class=%0d max=%h exp err=1 ready=1 class=9 max=7f",
               bus_if.err, bus_if.ready, bus_if.out_class, bus_if.out_max);
    end
    $display("err_set: err=%b", bus_if.err);
    check_read("buf9_kept", 4'd9, 8'd127);
    pulse_start();
    checks++;
    if (bus_if.err !== 1'b0 || bus_if.ready !== 1'b0 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got err=%b ready=%b busy=%b exp err=0 ready=0 busy=1",
               bus_if.err, bus_if.ready, bus_if.busy);
    end
    $display("err_clear: err=%b ready=%b", bus_if.err, bus_if.ready);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 8'd40 + 8'(i);
      step();
    end
    bus_if.in_valid = 1'b0;
    bus_if.rd_addr  = 4'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("reset_mid");
    check_read("buf0_cleared", 4'd0, 8'd0);
    pulse_start();
    vec = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    feed(-1, 0);
    check_result("after_reset", 4'd0, 8'd5);
  endtask

  task automatic test_start_coincident();
    bus_if.start    = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'd99;
    step();
    bus_if.start    = 1'b0;
    bus_if.in_valid = 1'b0;
    vec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    feed(-1, 0);
    check_result("start_coincident", 4'd0, 8'd1);
    checks++;
    if (bus_if.err !== 1'b0) begin
      errors++;
      $display("FAIL coincident_err got %b exp 0", bus_if.err);
    end
    check_read("buf0_one", 4'd0, 8'd1);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'd0;
    bus_if.rd_addr  = 4'd0;
    test_reset();
    test_back_to_back();
    test_negative_gap();
    test_last_index();
    test_err();
    test_reset_mid();
    test_start_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
